// File: rtl/pcie_cc_responder.sv
// rtl/pcie_cc_responder.sv - CQ/CC responder for single-DW accesses to a 16x32 BAR0 register file
// Optional PCIE_CC_UR_EN: unsupported reads return an Unsupported Request completion.
module pcie_cc_responder #(
  parameter int          C_DATA_WIDTH = 64,
  parameter int          KEEP_WIDTH   = C_DATA_WIDTH / 32,
  parameter logic [31:0] REG_ID       = 32'h55544C50
) (
  input  logic                    user_clk,
  input  logic                    user_reset,
  input  logic [15:0]             completer_id,
  input  logic [C_DATA_WIDTH-1:0] m_axis_cq_tdata,
  input  logic [84:0]             m_axis_cq_tuser,
  input  logic                    m_axis_cq_tlast,
  input  logic [KEEP_WIDTH-1:0]   m_axis_cq_tkeep,
  input  logic                    m_axis_cq_tvalid,
  output logic                    m_axis_cq_tready,
  output logic [C_DATA_WIDTH-1:0] s_axis_cc_tdata,
  output logic [32:0]             s_axis_cc_tuser,
  output logic                    s_axis_cc_tlast,
  output logic [KEEP_WIDTH-1:0]   s_axis_cc_tkeep,
  output logic                    s_axis_cc_tvalid,
  input  logic                    s_axis_cc_tready,
  output logic [31:0]             ctrl_reg,
  input  logic [31:0]             status_in
);

`ifdef PCIE_CC_UR_EN
  localparam logic UR_EN = 1'b1;
`else
  localparam logic UR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {CQ_D0, CQ_D1, CQ_DATA, CQ_DRAIN, CC_B0, CC_B1} state_t;

  state_t      state, state_nxt;
  logic [31:0] regs [16];
  logic [4:0]  addr_q;
  logic [15:0] req_id_q;
  logic [7:0]  tag_q;
  logic [2:0]  tc_q, attr_q;
  logic [31:0] rdata_q;
  logic        ur_q, resp_q;

  logic        cq_hs, cc_hs;
  logic [10:0] dword_count;
  logic [3:0]  req_type;
  logic [2:0]  bar_id;
  logic        bar0_single, is_rd, is_wr, is_ur_rd, resp_now, wr_en;
  logic [31:0] rd_mux, dw0, dw1, dw2;
  logic        unused_ok;

  assign cq_hs = m_axis_cq_tvalid && m_axis_cq_tready;
  assign cc_hs = s_axis_cc_tvalid && s_axis_cc_tready;

  assign dword_count = m_axis_cq_tdata[10:0];
  assign req_type    = m_axis_cq_tdata[14:11];
  assign bar_id      = m_axis_cq_tdata[50:48];
  assign bar0_single = (bar_id == 3'd0) && (dword_count == 11'd1);
  assign is_rd       = (req_type == 4'b0000) && bar0_single;
  assign is_wr       = (req_type == 4'b0001) && bar0_single;
  assign is_ur_rd    = (req_type == 4'b0000) && !bar0_single;
  assign resp_now    = is_rd || (UR_EN && is_ur_rd);

  // Registers 0 and 2 are read-only views (ID constant and live status).
  assign wr_en = cq_hs && (state == CQ_DATA) && (addr_q[3:0] != 4'd0) && (addr_q[3:0] != 4'd2);

  always_comb begin
    rd_mux = regs[addr_q[3:0]];
    if (addr_q[3:0] == 4'd0)
      rd_mux = REG_ID;
    else if (addr_q[3:0] == 4'd2)
      rd_mux = status_in;
  end

  always_ff @(posedge user_clk) begin
    if (user_reset)
      state <= CQ_D0;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CQ_D0:
        if (cq_hs)
          state_nxt = m_axis_cq_tlast ? CQ_D0 : CQ_D1;
      CQ_D1:
        if (cq_hs) begin
          if (m_axis_cq_tlast)
            state_nxt = resp_now ? CC_B0 : CQ_D0;
          else if (is_wr)
            state_nxt = CQ_DATA;
          else
            state_nxt = CQ_DRAIN;
        end
      CQ_DATA:
        if (cq_hs)
          state_nxt = m_axis_cq_tlast ? CQ_D0 : CQ_DRAIN;
      CQ_DRAIN:
        if (cq_hs && m_axis_cq_tlast)
          state_nxt = resp_q ? CC_B0 : CQ_D0;
      CC_B0:
        if (cc_hs)
          state_nxt = CC_B1;
      CC_B1:
        if (cc_hs)
          state_nxt = CQ_D0;
      default:
        state_nxt = CQ_D0;
    endcase
  end

  assign dw0 = {3'b000, 13'd4, 9'd0, addr_q, 2'b00};
  assign dw1 = {req_id_q, 2'b00, (ur_q ? 3'b001 : 3'b000), (ur_q ? 11'd0 : 11'd1)};
  assign dw2 = {1'b0, attr_q, tc_q, 1'b1, completer_id, tag_q};

  always_comb begin
    m_axis_cq_tready = 1'b0;
    s_axis_cc_tvalid = 1'b0;
    s_axis_cc_tlast  = 1'b0;
    s_axis_cc_tkeep  = '0;
    s_axis_cc_tdata  = '0;
    case (state)
      CQ_D0, CQ_D1, CQ_DATA, CQ_DRAIN:
        m_axis_cq_tready = !user_reset;
      CC_B0: begin
        s_axis_cc_tvalid = 1'b1;
        s_axis_cc_tkeep  = {KEEP_WIDTH{1'b1}};
        s_axis_cc_tdata  = {dw1, dw0};
      end
      CC_B1: begin
        s_axis_cc_tvalid = 1'b1;
        s_axis_cc_tlast  = 1'b1;
        s_axis_cc_tkeep  = ur_q ? KEEP_WIDTH'(1) : {KEEP_WIDTH{1'b1}};
        s_axis_cc_tdata  = {(ur_q ? 32'h0 : rdata_q), dw2};
      end
      default: ;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      for (int i = 0; i < 16; i++)
        regs[i] <= '0;
      addr_q   <= '0;
      req_id_q <= '0;
      tag_q    <= '0;
      tc_q     <= '0;
      attr_q   <= '0;
      rdata_q  <= '0;
      ur_q     <= 1'b0;
      resp_q   <= 1'b0;
    end else begin
      if (cq_hs && state == CQ_D0)
        addr_q <= m_axis_cq_tdata[6:2];
      // Read data is sampled with the descriptor so the completion reflects that instant.
      if (cq_hs && state == CQ_D1) begin
        req_id_q <= m_axis_cq_tdata[31:16];
        tag_q    <= m_axis_cq_tdata[39:32];
        tc_q     <= m_axis_cq_tdata[59:57];
        attr_q   <= m_axis_cq_tdata[62:60];
        rdata_q  <= rd_mux;
        ur_q     <= UR_EN && is_ur_rd;
        resp_q   <= resp_now;
      end
      if (wr_en)
        for (int b = 0; b < 4; b++)
          if (m_axis_cq_tuser[b])
            regs[addr_q[3:0]][8*b +: 8] <= m_axis_cq_tdata[8*b +: 8];
    end
  end

  assign ctrl_reg        = regs[1];
  assign s_axis_cc_tuser = '0;

  assign unused_ok = &{1'b0, m_axis_cq_tdata[47:40], m_axis_cq_tdata[56:51],
                       m_axis_cq_tdata[63], m_axis_cq_tuser[84:4], m_axis_cq_tkeep};

endmodule
